if_stage_ctrl: RTL and testbench
================================

Name: if_stage_ctrl

Overview:
Consumer end of the hazard-control interface. It owns the PC register and the IF/ID pipeline register, and applies the stall, flush and branch-redirect commands that the hazard detection unit issues. It sits between instruction memory and the ID stage. It also keeps hazard performance counters (stall cycles, flushes, longest stall run) for debug readout.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
CNT_WIDTH, 16, width of each performance counter
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
PCWrite_i  input  1  1 = PC may update this cycle; 0 = hold PC (load-use stall)
IFIDWrite_i  input  1  1 = IF/ID may load; 0 = hold IF/ID
IDFlush_i  input  1  1 = IF/ID loads NOP next edge
PCSrc_i  input  1  1 = branch taken; redirect fetch
branch_target_i  input  32  redirect address; bits [1:0] ignored
instr_i  input  32  instruction memory read data for address pc_o (combinational)
pc_o  output  32  current fetch address; bits [1:0] always 0
IFID_pc4_o  output  32  registered PC+4 of the instruction held in IF/ID
IFID_instr_o  output  32  registered instruction held in IF/ID
IFID_valid_o  output  1  1 = IF/ID holds a real fetched instruction; 0 = bubble
stall_cnt_o  output  CNT_WIDTH  cycles with PCWrite_i=0 and PCSrc_i=0
flush_cnt_o  output  CNT_WIDTH  number of redirect cycles (PCSrc_i=1)
max_stall_o  output  CNT_WIDTH  longest run of consecutive stall cycles seen
state_o  output  2  FSM state: 0 RUN, 1 STALL, 2 REDIR

Behaviour:
- Reset (asynchronous, while rst_i=1):
  - pc_o=PC_RESET; IFID_instr_o=NOP_INSTR; IFID_pc4_o=0; IFID_valid_o=0.
  - All counters 0; the internal run counter 0; state RUN.
- Per-edge priority: redirect > stall > normal.
- Redirect (PCSrc_i=1), regardless of PCWrite_i, IFIDWrite_i or IDFlush_i:
  - pc_o <= {branch_target_i[31:2],2'b00}.
  - IF/ID <= {NOP_INSTR, pc4=0}; valid <= 0.
  - flush_cnt_o increments; state <= REDIR.
- Stall/flush when PCSrc_i=0 (PC and IF/ID controls are independent):
  - PCWrite_i=0: pc_o holds. PCWrite_i=1: pc_o <= pc_o+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - IDFlush_i=1: IF/ID <= NOP, valid 0. This overrides IFIDWrite_i.
  - Else IFIDWrite_i=0: IF/ID holds all fields, including valid.
  - Else IF/ID <= {instr_i, pc_o+4}; valid <= 1.
- Stall accounting (cycle with PCWrite_i=0 and PCSrc_i=0):
  - stall_cnt_o increments; run counter increments.
  - max_stall_o <= max(max_stall_o, run+1); state <= STALL.
- Any cycle that is not a stall cycle clears the run counter. A redirect during STALL ends the run and does not count as a stall cycle.
- FSM next state:
  - REDIR when PCSrc_i=1.
  - Else STALL when PCWrite_i=0.
  - Else RUN.
  - REDIR lasts exactly one cycle unless PCSrc_i is re-asserted.
- Counters saturate at all-ones and never wrap; max_stall_o and the run counter saturate likewise.
- Latency: every command takes effect on the next rising edge. There is no combinational path from inputs to any output.
- rst_i asserted mid-stall or mid-redirect: immediate return to reset values. The first edge after deassertion fetches from PC_RESET as a normal cycle.

Test Plan:
- Reset, then 3 normal cycles with instr_i=pc-dependent pattern -> pc_o 0,4,8,12; IFID_pc4_o=12 and IFID_valid_o=1 after the third edge; state RUN.
- Load-use stall: PCWrite_i=IFIDWrite_i=0 for 1 cycle at pc_o=0x10 -> pc_o stays 0x10; IF/ID unchanged; stall_cnt_o=1, max_stall_o=1, state STALL, then RUN.
- PCSrc_i=1 with branch_target_i=0x0000_0043 while PCWrite_i=0 -> pc_o=0x40, IFID_instr_o=NOP_INSTR, valid 0, flush_cnt_o=1, stall_cnt_o unchanged, state REDIR.
- Stall runs of 3, then 1, then 2 cycles separated by normal cycles -> stall_cnt_o=6, max_stall_o=3.
- CNT_WIDTH=4: 20 stall cycles -> stall_cnt_o=4'hF and stays there; PC wrap from 0xFFFF_FFFC -> 0x0000_0000.
- rst_i pulsed asynchronously (between edges) mid-stall -> outputs return to reset values immediately; after release, first edge gives pc_o=4 and valid=1.

Source files
------------

// File: rtl/if_stage_ctrl.sv
// rtl/if_stage_ctrl.sv - PC register, IF/ID pipeline register and hazard counters driven by hazard-unit commands
module if_stage_ctrl #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 PCWrite_i,
  input  logic                 IFIDWrite_i,
  input  logic                 IDFlush_i,
  input  logic                 PCSrc_i,
  input  logic [31:0]          branch_target_i,
  input  logic [31:0]          instr_i,
  output logic [31:0]          pc_o,
  output logic [31:0]          IFID_pc4_o,
  output logic [31:0]          IFID_instr_o,
  output logic                 IFID_valid_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o,
  output logic [CNT_WIDTH-1:0] max_stall_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]          PC_INIT = {PC_RESET[31:2], 2'b00};

  state_t               state_q, state_d;
  logic [31:0]          pc_q, ifid_pc4_q, ifid_instr_q;
  logic                 ifid_valid_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q, max_stall_q, run_q;

  logic [31:0]          pc_plus4;
  logic                 stall_cyc;
  logic [CNT_WIDTH-1:0] run_inc, stall_inc, flush_inc;

  assign pc_plus4  = pc_q + 32'd4;
  assign stall_cyc = !PCSrc_i && !PCWrite_i;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign run_inc   = (run_q       == CNT_MAX) ? run_q       : run_q + CNT_ONE;
  assign stall_inc = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_ONE;
  assign flush_inc = (flush_cnt_q == CNT_MAX) ? flush_cnt_q : flush_cnt_q + CNT_ONE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (PCSrc_i) begin
      state_d = ST_REDIR;
    end else if (!PCWrite_i) begin
      state_d = ST_STALL;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q         <= PC_INIT;
      ifid_pc4_q   <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (PCSrc_i) begin
      pc_q         <= {branch_target_i[31:2], 2'b00};
      ifid_pc4_q   <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      if (PCWrite_i) begin
        pc_q <= pc_plus4;
      end
      // Flush wins over hold; hold keeps every IF/ID field including valid.
      if (IDFlush_i) begin
        ifid_pc4_q   <= 32'd0;
        ifid_instr_q <= NOP_INSTR;
        ifid_valid_q <= 1'b0;
      end else if (IFIDWrite_i) begin
        ifid_pc4_q   <= pc_plus4;
        ifid_instr_q <= instr_i;
        ifid_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      max_stall_q <= '0;
      run_q       <= '0;
    end else begin
      if (PCSrc_i) begin
        flush_cnt_q <= flush_inc;
      end
      if (stall_cyc) begin
        stall_cnt_q <= stall_inc;
        run_q       <= run_inc;
        if (run_inc > max_stall_q) begin
          max_stall_q <= run_inc;
        end
      end else begin
        run_q <= '0;
      end
    end
  end

  assign pc_o         = pc_q;
  assign IFID_pc4_o   = ifid_pc4_q;
  assign IFID_instr_o = ifid_instr_q;
  assign IFID_valid_o = ifid_valid_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign max_stall_o  = max_stall_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// tb/tb_if_stage_ctrl.sv - randomized model-checked bench for if_stage_ctrl (16-bit and 4-bit counter builds)
module tb_if_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        PCWrite_i = 1'b1, IFIDWrite_i = 1'b1, IDFlush_i = 1'b0, PCSrc_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
  logic [31:0] instr_i;

  logic [31:0] pc_a, pc4_a, instr_a;
  logic        valid_a;
  logic [15:0] stall_a, flush_a, max_a;
  logic [1:0]  state_a;

  logic [31:0] pc_b, pc4_b, instr_b;
  logic        valid_b;
  logic [3:0]  stall_b, flush_b, max_b;
  logic [1:0]  state_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: plain integers, saturation applied only when compared.
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  int          m_stall, m_flush, m_max, m_run, m_state;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h1357_9BDF) + {a[7:0], 24'h0};
  endfunction

  assign instr_i = mem_word(pc_a);

  if_stage_ctrl #(.PC_RESET(32'h0), .CNT_WIDTH(16), .NOP_INSTR(NOP)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .PCWrite_i(PCWrite_i), .IFIDWrite_i(IFIDWrite_i),
    .IDFlush_i(IDFlush_i), .PCSrc_i(PCSrc_i), .branch_target_i(branch_target_i),
    .instr_i(instr_i), .pc_o(pc_a), .IFID_pc4_o(pc4_a), .IFID_instr_o(instr_a),
    .IFID_valid_o(valid_a), .stall_cnt_o(stall_a), .flush_cnt_o(flush_a),
    .max_stall_o(max_a), .state_o(state_a));

  if_stage_ctrl #(.PC_RESET(32'h0), .CNT_WIDTH(4), .NOP_INSTR(NOP)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .PCWrite_i(PCWrite_i), .IFIDWrite_i(IFIDWrite_i),
    .IDFlush_i(IDFlush_i), .PCSrc_i(PCSrc_i), .branch_target_i(branch_target_i),
    .instr_i(instr_i), .pc_o(pc_b), .IFID_pc4_o(pc4_b), .IFID_instr_o(instr_b),
    .IFID_valid_o(valid_b), .stall_cnt_o(stall_b), .flush_cnt_o(flush_b),
    .max_stall_o(max_b), .state_o(state_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_pc4 = 32'd0; m_instr = NOP; m_valid = 1'b0;
    m_stall = 0; m_flush = 0; m_max = 0; m_run = 0; m_state = 0;
  endtask

  task automatic check_all();
    check("pc",       pc_a,              m_pc);
    check("pc4",      pc4_a,             m_pc4);
    check("instr",    instr_a,           m_instr);
    check("valid",    {31'd0, valid_a},  {31'd0, m_valid});
    check("stall16",  {16'd0, stall_a},  sat(m_stall, 16));
    check("flush16",  {16'd0, flush_a},  sat(m_flush, 16));
    check("max16",    {16'd0, max_a},    sat(m_max, 16));
    check("state",    {30'd0, state_a},  m_state);
    check("pc_w4",    pc_b,              m_pc);
    check("valid_w4", {31'd0, valid_b},  {31'd0, m_valid});
    check("stall4",   {28'd0, stall_b},  sat(m_stall, 4));
    check("flush4",   {28'd0, flush_b},  sat(m_flush, 4));
    check("max4",     {28'd0, max_b},    sat(m_max, 4));
    check("state_w4", {30'd0, state_b},  m_state);
  endtask

  // Drive one cycle of commands, advance the model by the same rules, then compare.
  task automatic step(input logic pcw, input logic ifw, input logic fl, input logic src,
                      input logic [31:0] tgt);
    PCWrite_i = pcw; IFIDWrite_i = ifw; IDFlush_i = fl; PCSrc_i = src; branch_target_i = tgt;
    @(posedge clk_i);
    if (src) begin
      m_pc = tgt & ~32'd3; m_instr = NOP; m_pc4 = 0; m_valid = 0;
      m_flush++; m_run = 0; m_state = 2;
    end else begin
      if (fl) begin
        m_instr = NOP; m_pc4 = 0; m_valid = 0;
      end else if (ifw) begin
        m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1;
      end
      if (pcw) begin
        m_pc = m_pc + 32'd4; m_run = 0; m_state = 0;
      end else begin
        m_stall++; m_run++; m_state = 1;
        if (m_run > m_max) m_max = m_run;
      end
    end
    #1;
    check_all();
  endtask

  task automatic normal(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 32'd0);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    @(negedge clk_i);
    rst_i = 1'b0;

    normal(3);
    check("plan_pc12",  pc_a, 32'd12);
    check("plan_pc4_12", pc4_a, 32'd12);
    normal(1);
    stall(1);
    check("plan_stall_pc", pc_a, 32'h10);
    check("plan_stall_st", {30'd0, state_a}, 32'd1);
    normal(1);

    step(0, 0, 0, 1, 32'h0000_0043);
    check("plan_redir_pc", pc_a, 32'h40);
    check("plan_redir_fl", {16'd0, flush_a}, 32'd1);
    normal(1);

    stall(3); normal(1); stall(1); normal(2); stall(2); normal(1);
    check("plan_max3", {16'd0, max_a}, 32'd3);

    step(1, 0, 1, 0, 32'd0);
    step(1, 0, 0, 0, 32'd0);
    step(0, 1, 0, 0, 32'd0);

    stall(20);
    check("plan_sat4", {28'd0, stall_b}, 32'hF);
    step(0, 0, 0, 1, 32'hFFFF_FFFE);
    normal(1);
    check("plan_wrap", pc_a, 32'd0);
    normal(2);

    stall(2);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst_i = 1'b0;
    normal(1);
    check("plan_post_rst", pc_a, 32'd4);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      logic        pcw;
      pcw = ($urandom_range(0, 99) < 60);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step(pcw, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 11) == 0), tgt);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 rst_i = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
